// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM arbitration slice: RAM status, data word, arbiter state.
// Latency: n/a (types and default parameters only).
// Backpressure: n/a.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // RAM port status as reported by the RAM model each cycle.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Which master currently owns the shared RAM port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    localparam int unsigned BURST_LEN_DEF    = 2;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of icache, dcache and RAM-side signals around the shared RAM port.
// Latency: n/a (wiring only).
// Backpressure: iwait/dwait stall the caches; ramstate stalls the arbiter.
// Modports: slave = arbiter view, master = caches + RAM environment view.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    // icache side
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    // dcache side
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    // RAM side
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// Grants the single RAM port to the icache or dcache; dcache blocks held atomically, icache aged.
// Latency: 1 arbitration cycle before RAM enables, plus RAM latency; 1 idle cycle on release.
// Backpressure: iwait/dwait stay high until ramstate=ACCESS for the owner; ERROR is a stall.
// Ports: CLK, nRST (async active-low); bus (slave modport) carries cache and RAM
// handshakes; err_cnt reports saturating count of RAM ERROR cycles.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned BURST_LEN    = BURST_LEN_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic            CLK,
    input  logic            nRST,
    mem_arbiter_if.slave    bus,
    output logic [15:0]     err_cnt
);

    localparam int unsigned BW = $clog2(BURST_LEN) + 1;
    // burst_cnt reaching BURST_LEN is detected one word early so it never has to hold that value.
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [2:0]    STARVE_LIM = 3'(STARVE_LIMIT);

    arb_state_t    state_q,  state_d;
    logic [BW-1:0] burst_q,  burst_d;
    logic [2:0]    starve_q, starve_d;
    logic [15:0]   err_q,    err_d;

    logic dreq;
    logic word_done;

    assign dreq      = bus.dREN | bus.dWEN;
    assign word_done = (bus.ramstate == ACCESS);
    assign err_cnt   = err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            burst_q  <= '0;
            starve_q <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            burst_q  <= burst_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // Next-state, burst and aging counters.
    always_comb begin
        state_d  = state_q;
        burst_d  = burst_q;
        starve_d = starve_q;

        case (state_q)
            IDLE: begin
                burst_d = '0;
                if (bus.iREN && (starve_q >= STARVE_LIM)) begin
                    state_d = IGNT;
                end else if (dreq) begin
                    state_d = DGNT;
                    // icache lost this arbitration
                    if (bus.iREN && (starve_q != 3'd7)) begin
                        starve_d = starve_q + 3'd1;
                    end
                end else if (bus.iREN) begin
                    state_d = IGNT;
                end
            end
            IGNT: begin
                if (!bus.iREN || word_done) begin
                    state_d = IDLE;
                end
            end
            DGNT: begin
                if (!dreq) begin
                    state_d = IDLE;
                    burst_d = '0;
                end else if (word_done) begin
                    if (burst_q == BURST_LAST) begin
                        state_d = IDLE;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                burst_d = '0;
            end
        endcase

        if (!bus.iREN || ((state_d == IGNT) && (state_q != IGNT))) begin
            starve_d = '0;
        end
    end

    always_comb begin
        err_d = err_q;
        if ((bus.ramstate == ERROR) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    // RAM-side mux and cache responses, driven only from the registered owner so
    // two masters can never be presented in the same cycle.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;

        case (state_q)
            IGNT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                bus.iload   = bus.ramload;
                bus.iwait   = !word_done;
            end
            DGNT: begin
                // a simultaneous read and write request is treated as a write
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dload    = bus.ramload;
                bus.dwait    = !word_done;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: queue-driven caches, reactive RAM, ownership model.
// Latency: RAM answers ACCESS after RAM_LAT BUSY cycles of a held request.
// Backpressure: cache queues pop only on a cycle the model predicts wait low.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int RAM_LAT = 2;
    localparam int BLEN    = 2;
    localparam int SLIM    = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } dreq_t;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [15:0] err_cnt;

    mem_arbiter_if bus();

    mem_arbiter #(.BURST_LEN(BLEN), .STARVE_LIMIT(SLIM)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    always #5 CLK = ~CLK;

    logic [31:0] iq[$];
    dreq_t       dq[$];
    word_t       mem [word_t];
    logic [32:0] dut_log[$];
    logic [32:0] mdl_log[$];

    // model: 0 = nobody owns the RAM, 1 = icache, 2 = dcache
    int m_owner, m_words, m_losses, m_err;
    int ram_cnt, err_left;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic word_t ram_word(input word_t a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE0000;
    endfunction

    task automatic model_reset();
        m_owner  = 0;
        m_words  = 0;
        m_losses = 0;
        m_err    = 0;
        ram_cnt  = 0;
    endtask

    // Advance the model across a rising edge using the cycle's settled inputs.
    task automatic model_step();
        bit acc;
        bit dreq;
        int nxt;
        if (!nRST) begin
            model_reset();
            return;
        end
        acc  = (bus.ramstate == ACCESS);
        dreq = bus.dREN | bus.dWEN;
        if (m_owner == 1 && acc) begin
            mdl_log.push_back({1'b1, bus.iaddr});
            if (iq.size() != 0) void'(iq.pop_front());
        end
        if (m_owner == 2 && acc) begin
            mdl_log.push_back({1'b0, bus.daddr});
            if (bus.dWEN) mem[bus.daddr] = bus.dstore;
            if (dq.size() != 0) void'(dq.pop_front());
        end
        nxt = m_owner;
        case (m_owner)
            0: begin
                if (bus.iREN && m_losses >= SLIM) nxt = 1;
                else if (dreq) begin
                    nxt = 2;
                    m_words = 0;
                    if (bus.iREN) m_losses = (m_losses < 7) ? m_losses + 1 : 7;
                end else if (bus.iREN) nxt = 1;
            end
            1: if (!bus.iREN || acc) nxt = 0;
            default: begin
                if (!dreq) nxt = 0;
                else if (acc) begin
                    m_words++;
                    if (m_words == BLEN) nxt = 0;
                end
            end
        endcase
        if (!bus.iREN || (nxt == 1 && m_owner != 1)) m_losses = 0;
        m_owner = nxt;
        if (bus.ramstate == ERROR && m_err < 65535) m_err++;
        if (bus.ramstate == BUSY) ram_cnt++;
        else if (bus.ramstate != ERROR) ram_cnt = 0;
    endtask

    task automatic drive_inputs();
        bus.iREN   = (iq.size() != 0);
        bus.iaddr  = (iq.size() != 0) ? iq[0] : 32'h0;
        bus.dREN   = (dq.size() != 0) && !dq[0].we;
        bus.dWEN   = (dq.size() != 0) && dq[0].we;
        bus.daddr  = (dq.size() != 0) ? dq[0].addr : 32'h0;
        bus.dstore = (dq.size() != 0 && dq[0].we) ? dq[0].data : 32'h0;
    endtask

    // RAM environment: reacts to whatever request the arbiter presents.
    task automatic ram_respond();
        bus.ramload = 32'h0;
        if (!(bus.ramREN || bus.ramWEN)) begin
            bus.ramstate = FREE;
        end else if (err_left > 0) begin
            bus.ramstate = ERROR;
            err_left--;
        end else if (ram_cnt >= RAM_LAT) begin
            bus.ramstate = ACCESS;
            if (bus.ramREN) bus.ramload = ram_word(bus.ramaddr);
        end else begin
            bus.ramstate = BUSY;
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the ownership model.
    task automatic compare_all();
        logic e_ren, e_wen, e_iw, e_dw;
        word_t e_addr, e_st, e_il, e_dl;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_st = '0; e_il = '0; e_dl = '0;
        if (m_owner == 1) begin
            e_ren  = bus.iREN;
            e_addr = bus.iaddr;
            e_il   = bus.ramload;
        end else if (m_owner == 2) begin
            e_ren  = bus.dREN & ~bus.dWEN;
            e_wen  = bus.dWEN;
            e_addr = bus.daddr;
            e_st   = bus.dstore;
            e_dl   = bus.ramload;
        end
        e_iw = !(m_owner == 1 && bus.ramstate == ACCESS);
        e_dw = !(m_owner == 2 && bus.ramstate == ACCESS);
        chk("ramREN",   bus.ramREN,   e_ren);
        chk("ramWEN",   bus.ramWEN,   e_wen);
        chk("ramaddr",  bus.ramaddr,  e_addr);
        chk("ramstore", bus.ramstore, e_st);
        chk("iwait",    bus.iwait,    e_iw);
        chk("dwait",    bus.dwait,    e_dw);
        chk("iload",    bus.iload,    e_il);
        chk("dload",    bus.dload,    e_dl);
        chk("err_cnt",  err_cnt,      m_err);
        if (bus.iwait === 1'b0) dut_log.push_back({1'b1, bus.ramaddr});
        if (bus.dwait === 1'b0) dut_log.push_back({1'b0, bus.ramaddr});
    endtask

    // One clock cycle; returns at the falling edge with outputs already compared.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1 drive_inputs();
        #1 ram_respond();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        iq.delete();
        dq.delete();
        err_left = 0;
        model_reset();
        drive_inputs();
        #1 ram_respond();
        tick();
        tick();
        #2 nRST = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((iq.size() != 0 || dq.size() != 0 || m_owner != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, (n >= budget), 1'b0);
    endtask

    task automatic check_seq(input string name, input int bd, input int bm, input logic [32:0] exp[$]);
        chk({name, "_dut_len"}, dut_log.size() - bd, exp.size());
        chk({name, "_mdl_len"}, mdl_log.size() - bm, exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            if (bd + k < dut_log.size()) chk($sformatf("%s_dut%0d", name, k), dut_log[bd + k], exp[k]);
            if (bm + k < mdl_log.size()) chk($sformatf("%s_mdl%0d", name, k), mdl_log[bm + k], exp[k]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] exp[$];
        int bd, bm;

        nRST = 1'b0;
        bus.ramstate = FREE;
        bus.ramload  = '0;
        mem[32'h40] = 32'hDEADBEEF;

        // reset values, observed while reset is held
        nRST = 1'b0;
        model_reset();
        drive_inputs();
        tick();
        chk("rst_ramREN", bus.ramREN, 1'b0);
        chk("rst_ramWEN", bus.ramWEN, 1'b0);
        chk("rst_iwait",  bus.iwait,  1'b1);
        chk("rst_dwait",  bus.dwait,  1'b1);
        chk("rst_iload",  bus.iload,  32'h0);
        chk("rst_dload",  bus.dload,  32'h0);
        chk("rst_errcnt", err_cnt,    16'h0);

        // icache only: 0x40, two BUSY cycles then ACCESS
        do_reset();
        iq.push_back(32'h40);
        tick();
        chk("t1_c0_ramREN", bus.ramREN, 1'b0);
        tick();
        chk("t1_c1_ramREN", bus.ramREN, 1'b1);
        chk("t1_c1_addr",   bus.ramaddr, 32'h40);
        chk("t1_c1_iwait",  bus.iwait,  1'b1);
        tick();
        chk("t1_c2_iwait",  bus.iwait,  1'b1);
        tick();
        chk("t1_c3_iwait",  bus.iwait,  1'b0);
        chk("t1_c3_iload",  bus.iload,  32'hDEADBEEF);
        tick();
        chk("t1_c4_ramREN", bus.ramREN, 1'b0);
        chk("t1_c4_iwait",  bus.iwait,  1'b1);

        // simultaneous icache and dcache requests
        do_reset();
        bd = dut_log.size(); bm = mdl_log.size();
        iq.push_back(32'h80);
        dq.push_back('{we: 1'b0, addr: 32'h100, data: 32'h0});
        dq.push_back('{we: 1'b0, addr: 32'h104, data: 32'h0});
        wait_done("t2", 100);
        exp = '{{1'b0, 32'h100}, {1'b0, 32'h104}, {1'b1, 32'h80}};
        check_seq("t2", bd, bm, exp);

        // write-back pair then fill pair, icache waiting throughout
        do_reset();
        bd = dut_log.size(); bm = mdl_log.size();
        iq.push_back(32'hC0);
        dq.push_back('{we: 1'b1, addr: 32'h200, data: 32'hA0A00200});
        dq.push_back('{we: 1'b1, addr: 32'h204, data: 32'hA0A00204});
        dq.push_back('{we: 1'b0, addr: 32'h300, data: 32'h0});
        dq.push_back('{we: 1'b0, addr: 32'h304, data: 32'h0});
        wait_done("t3", 200);
        exp = '{{1'b0, 32'h200}, {1'b0, 32'h204}, {1'b0, 32'h300}, {1'b0, 32'h304}, {1'b1, 32'hC0}};
        check_seq("t3", bd, bm, exp);

        // starvation: five dcache blocks queued, icache wins after four losses
        do_reset();
        bd = dut_log.size(); bm = mdl_log.size();
        iq.push_back(32'h140);
        for (int k = 0; k < 10; k++) dq.push_back('{we: 1'b0, addr: 32'h1000 + 32'(4 * k), data: 32'h0});
        wait_done("t4", 400);
        exp.delete();
        for (int k = 0; k < 8; k++) exp.push_back({1'b0, 32'h1000 + 32'(4 * k)});
        exp.push_back({1'b1, 32'h140});
        exp.push_back({1'b0, 32'h1020});
        exp.push_back({1'b0, 32'h1024});
        check_seq("t4", bd, bm, exp);

        // three ERROR cycles during a dcache grant
        do_reset();
        bd = dut_log.size(); bm = mdl_log.size();
        err_left = 3;
        dq.push_back('{we: 1'b0, addr: 32'h600, data: 32'h0});
        dq.push_back('{we: 1'b0, addr: 32'h604, data: 32'h0});
        tick();
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("t5_err%0d_dwait", k), bus.dwait, 1'b1);
            chk($sformatf("t5_err%0d_ramREN", k), bus.ramREN, 1'b1);
            chk($sformatf("t5_err%0d_addr", k), bus.ramaddr, 32'h600);
        end
        tick();
        chk("t5_errcnt_after", err_cnt, 16'd3);
        wait_done("t5", 100);
        chk("t5_errcnt_end", err_cnt, 16'd3);
        exp = '{{1'b0, 32'h600}, {1'b0, 32'h604}};
        check_seq("t5", bd, bm, exp);

        // reset pulled mid-write
        do_reset();
        dq.push_back('{we: 1'b1, addr: 32'h500, data: 32'h55AA55AA});
        tick();
        tick();
        chk("t6_pre_ramWEN", bus.ramWEN, 1'b1);
        #1 nRST = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_ramWEN", bus.ramWEN, 1'b0);
        chk("t6_rst_dwait",  bus.dwait,  1'b1);
        dq.delete();
        tick();
        tick();
        #2 nRST = 1'b1;
        iq.push_back(32'h240);
        tick();
        chk("t6_idle_ramREN", bus.ramREN, 1'b0);
        chk("t6_idle_ramWEN", bus.ramWEN, 1'b0);
        tick();
        chk("t6_grant_ramREN", bus.ramREN, 1'b1);
        chk("t6_grant_addr",   bus.ramaddr, 32'h240);
        wait_done("t6", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
